// File: rtl/msg_reader_pkg.sv
// msg_reader_pkg: shared types and constants for the msg_reader slice.
//   state_t  - reader FSM states
//   HDR_BYTES, MAX_LEN, ADDR_W - message framing constants
package msg_reader_pkg;

    localparam int          ADDR_W    = 16;
    localparam int          HDR_BYTES = 2;
    // Largest payload whose total (payload + header) still fits in ADDR_W bits.
    localparam logic [15:0] MAX_LEN   = 16'hFFFD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RDY,
        S_READ,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/msg_reader_fifo.sv
// msg_reader_fifo: synchronous first-word-fall-through FIFO for the output stream.
// Ports:
//   clk, rst_l     - clock, synchronous active-low reset
//   i_push, i_din  - write strobe / entry ({last, data})
//   i_pop          - read strobe (ignored when empty)
//   o_dout         - head entry (meaningful only when !o_empty)
//   o_empty        - FIFO empty
//   o_count        - occupancy, feeds the read-credit check in the top
module msg_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
    assign o_dout    = r_mem[r_rd];
    assign o_count   = r_count;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/msg_reader.sv
// msg_reader: read master for slave_device. On start it requests a message,
// sweeps rd_addr over the 2 header bytes plus payload, captures slv_data
// RD_LAT cycles after each address and streams the bytes out (valid/ready/last).
// The header bytes form the 16-bit sequence number reported on hdr_seq.
// Ports:
//   clk, rst_l                 - clock, synchronous active-low reset
//   start, msg_len             - command pulse and payload length (IDLE only)
//   busy                       - not IDLE
//   new_msg, slv_ready         - message request / slave ready
//   ram_rd_rq, rd_addr         - read strobe and address
//   slv_data                   - returned byte
//   out_data/valid/ready/last  - output byte stream
//   hdr_seq                    - header of last completed message
//   err                        - one-cycle error pulse
// Optional: define MSG_READER_SEQ_CHECK_EN to flag non-consecutive headers.
module msg_reader
    import msg_reader_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              start,
    input  logic [15:0]       msg_len,
    output logic              busy,
    output logic              new_msg,
    input  logic              slv_ready,
    output logic              ram_rd_rq,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        slv_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [15:0]       hdr_seq,
    output logic              err
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_total;
    logic [ADDR_W-1:0] r_idx;
    logic [WAIT_W-1:0] r_wait;
    logic [15:0]       r_hdr_tmp;
    logic [15:0]       r_hdr_seq;
    logic              r_err;
    logic [RD_LAT:1]   r_vld_pipe;
    logic [ADDR_W-1:0] r_idx_pipe [RD_LAT:1];
`ifdef MSG_READER_SEQ_CHECK_EN
    logic              r_first;
`endif

    logic              w_issue;
    logic              w_cap;
    logic [ADDR_W-1:0] w_cap_idx;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_inflight;
    logic [CNT_W-1:0]  w_free;
    logic              w_empty;
    logic              w_pop;
    logic [8:0]        w_dout;
    logic              w_drain_done;

    assign w_inflight = CNT_W'($countones(r_vld_pipe));
    assign w_free     = CNT_W'(FIFO_DEPTH) - w_count;
    // Reserve a FIFO slot for every read already in the pipe before issuing.
    assign w_issue    = (r_state == S_READ) && (w_free > w_inflight);
    assign w_cap      = r_vld_pipe[RD_LAT];
    assign w_cap_idx  = r_idx_pipe[RD_LAT];
    assign w_pop      = !w_empty && out_ready;
    // Finish in the cycle the last byte leaves so busy drops right after it.
    assign w_drain_done = (r_vld_pipe == '0) &&
                          (w_empty || (w_count == CNT_W'(1) && w_pop));

    msg_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .i_push  (w_cap),
        .i_din   ({(w_cap_idx == r_total - 16'd1), slv_data}),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Read-latency pipe: carries the index of each issued address.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_vld_pipe <= '0;
            r_hdr_tmp  <= '0;
            for (int i = 1; i <= RD_LAT; i++) r_idx_pipe[i] <= '0;
        end else begin
            r_vld_pipe[1] <= w_issue;
            r_idx_pipe[1] <= r_idx;
            for (int i = 2; i <= RD_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_idx_pipe[i] <= r_idx_pipe[i-1];
            end
            if (w_cap && w_cap_idx == 16'd0) r_hdr_tmp[15:8] <= slv_data;
            if (w_cap && w_cap_idx == 16'd1) r_hdr_tmp[7:0]  <= slv_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state   <= S_IDLE;
            r_total   <= '0;
            r_idx     <= '0;
            r_wait    <= '0;
            r_hdr_seq <= '0;
            r_err     <= 1'b0;
`ifdef MSG_READER_SEQ_CHECK_EN
            r_first   <= 1'b1;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (msg_len > MAX_LEN) begin
                            r_err <= 1'b1;
                        end else begin
                            r_total <= msg_len + 16'(HDR_BYTES);
                            r_idx   <= '0;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (slv_ready) begin
                        r_state <= S_READ;
                    end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_idx <= r_idx + 16'd1;
                        if (r_idx == r_total - 16'd1) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_done) begin
                        r_state   <= S_IDLE;
                        r_hdr_seq <= r_hdr_tmp;
`ifdef MSG_READER_SEQ_CHECK_EN
                        r_first   <= 1'b0;
                        if (!r_first && r_hdr_tmp != r_hdr_seq + 16'd1) r_err <= 1'b1;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign new_msg   = (r_state == S_REQ);
    assign ram_rd_rq = w_issue;
    assign rd_addr   = r_idx;
    assign out_valid = !w_empty;
    // Mask the un-reset storage so an empty FIFO presents zeros.
    assign out_data  = w_empty ? 8'h00 : w_dout[7:0];
    assign out_last  = !w_empty && w_dout[8];
    assign hdr_seq   = r_hdr_seq;
    assign err       = r_err;

endmodule
